// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the seq_mul shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

  // Counter width able to hold the values 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Bit index of the two's-complement sign bit of a width-bit operand.
  function automatic int sign_bit(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/seq_mul_if.sv
// Request/response bundle between the bus decoder (master) and seq_mul (slave).
interface seq_mul_if #(
  parameter int WIDTH = 16
);
  logic                 cs;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   product;
  logic                 ready;
  logic                 valid;

  modport master (
    output cs, is_signed, a, b,
    input  product, ready, valid
  );

  modport slave (
    input  cs, is_signed, a, b,
    output product, ready, valid
  );
endinterface

// File: rtl/mul_sign_adj.sv
// Sign handling around the unsigned shift-add core: operand magnitudes on the
// way in and the conditional two's-complement negate of the product on the way out.
module mul_sign_adj
  import mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               signed_i,
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic               neg_i,
  output logic [WIDTH-1:0]   mag_a_o,
  output logic [WIDTH-1:0]   mag_b_o,
  output logic               neg_o,
  output logic [2*WIDTH-1:0] prod_o
);
  localparam int MSB = sign_bit(WIDTH);
  localparam logic [WIDTH-1:0]   OP_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] PROD_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic a_neg_s;
  logic b_neg_s;

  assign a_neg_s = signed_i & a_i[MSB];
  assign b_neg_s = signed_i & b_i[MSB];

  // Magnitudes: -2^(WIDTH-1) negates to itself, which is its exact unsigned magnitude.
  always_comb begin
    mag_a_o = a_i;
    mag_b_o = b_i;
    if (a_neg_s) begin
      mag_a_o = ~a_i + OP_ONE;
    end else begin
      mag_a_o = a_i;
    end
    if (b_neg_s) begin
      mag_b_o = ~b_i + OP_ONE;
    end else begin
      mag_b_o = b_i;
    end
  end

  assign neg_o = a_neg_s ^ b_neg_s;

  // Final product: negate the full-width magnitude product when operand signs differ.
  always_comb begin
    prod_o = prod_i;
    if (neg_i) begin
      prod_o = ~prod_i + PROD_ONE;
    end else begin
      prod_o = prod_i;
    end
  end

endmodule

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first,
// fixed latency with a one-cycle valid pulse and a registered product.
module seq_mul
  import mul_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int SIGNED_EN = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  seq_mul_if.slave bus
);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mcand_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 ready_q;
  logic                 valid_q;

  logic                 signed_s;
  logic [WIDTH-1:0]     mag_a_s;
  logic [WIDTH-1:0]     mag_b_s;
  logic                 neg_s;
  logic [2*WIDTH-1:0]   prod_adj_s;
  logic [WIDTH:0]       addend_s;
  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH-1:0]   acc_step_s;

  // With SIGNED_EN=0 the mode input is ignored and every operation is unsigned.
  assign signed_s = (SIGNED_EN != 0) & bus.is_signed;

  mul_sign_adj #(.WIDTH(WIDTH)) u_sign_adj (
    .a_i      (bus.a),
    .b_i      (bus.b),
    .signed_i (signed_s),
    .prod_i   (acc_q),
    .neg_i    (neg_q),
    .mag_a_o  (mag_a_s),
    .mag_b_o  (mag_b_s),
    .neg_o    (neg_s),
    .prod_o   (prod_adj_s)
  );

  // One shift-add step: add the multiplicand on the current LSB, shift right keeping the carry.
  always_comb begin
    addend_s   = acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}};
    sum_s      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + addend_s;
    acc_step_s = {sum_s, acc_q[WIDTH-1:1]};
  end

  // Control FSM, counter, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      mcand_q   <= {WIDTH{1'b0}};
      neg_q     <= 1'b0;
      product_q <= {(2*WIDTH){1'b0}};
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.cs) begin
            mcand_q <= mag_a_s;
            acc_q   <= {{WIDTH{1'b0}}, mag_b_s};
            neg_q   <= neg_s;
            cnt_q   <= {CNT_W{1'b0}};
            ready_q <= 1'b0;
            state_q <= CALC;
          end else begin
            ready_q <= 1'b1;
          end
        end
        CALC: begin
          // cnt_q reaches WIDTH once every multiplier bit has been consumed.
          if (cnt_q == CNT_LAST) begin
            product_q <= prod_adj_s;
            valid_q   <= 1'b1;
            state_q   <= DONE;
          end else begin
            acc_q <= acc_step_s;
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.ready   = ready_q;
  assign bus.valid   = valid_q;

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul: a signed-capable and an unsigned-only instance
// run the same stimulus; a negedge monitor checks ready/valid/product each cycle.
module tb_seq_mul;
  localparam int W  = 16;
  localparam int PW = 2 * W;

  typedef struct {
    logic [PW-1:0] exp_s;
    logic [PW-1:0] exp_u;
    int            acc_edge;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          cs;
  logic          sgn;
  logic [W-1:0]  a;
  logic [W-1:0]  b;

  int            cyc      = 0;
  int            n_chk    = 0;
  int            n_fail   = 0;
  int            rdy_edge = 0;
  logic [PW-1:0] last_s;
  logic [PW-1:0] last_u;
  bit            exp_v;
  bit            rdy_m;
  exp_t          q[$];

  seq_mul_if #(.WIDTH(W)) bus_s ();
  seq_mul_if #(.WIDTH(W)) bus_u ();

  assign bus_s.cs        = cs;
  assign bus_s.is_signed = sgn;
  assign bus_s.a         = a;
  assign bus_s.b         = b;
  assign bus_u.cs        = cs;
  assign bus_u.is_signed = sgn;
  assign bus_u.a         = a;
  assign bus_u.b         = b;

  seq_mul #(.WIDTH(W), .SIGNED_EN(1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s.slave));
  seq_mul #(.WIDTH(W), .SIGNED_EN(0)) dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference product from plain integer arithmetic on the interpreted operand values.
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
    longint px;
    longint py;
    logic [63:0] full;
    px = s ? longint'($signed(x)) : longint'(x);
    py = s ? longint'($signed(y)) : longint'(y);
    full = 64'(px * py);
    return full[PW-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs against the timing model, record new accepts.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      rdy_m = (cyc >= rdy_edge);
      exp_v = (q.size() > 0) && (q[0].acc_edge + W + 1 == cyc);
      check("ready_s", 64'(bus_s.ready), 64'(rdy_m));
      check("ready_u", 64'(bus_u.ready), 64'(rdy_m));
      check("valid_s", 64'(bus_s.valid), 64'(exp_v));
      check("valid_u", 64'(bus_u.valid), 64'(exp_v));
      if (exp_v) begin
        last_s = q[0].exp_s;
        last_u = q[0].exp_u;
        void'(q.pop_front());
      end
      check("product_s", 64'(bus_s.product), 64'(last_s));
      check("product_u", 64'(bus_u.product), 64'(last_u));
      if (cs && rdy_m) begin
        q.push_back('{exp_s: ref_mul(a, b, sgn), exp_u: ref_mul(a, b, 1'b0), acc_edge: cyc + 1});
        rdy_edge = cyc + 1 + W + 2;
      end
    end
  end

  // Wait (bounded) until ready reaches the given level; sampled at posedge+2.
  task automatic wait_level(input logic v);
    int n;
    n = 0;
    while (bus_s.ready !== v && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check("ready_wait", 64'(bus_s.ready), 64'(v));
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    wait_level(1'b1);
    a = x; b = y; sgn = s; cs = 1'b1;
    @(posedge clk); #2;
    cs = 1'b0;
  endtask

  task automatic op_expect(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                           input logic [PW-1:0] es, input logic [PW-1:0] eu);
    op(x, y, s);
    wait_level(1'b1);
    check("direct_s", 64'(bus_s.product), 64'(es));
    check("direct_u", 64'(bus_u.product), 64'(eu));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; cs = 1'b0; sgn = 1'b0; a = '0; b = '0;
    last_s = '0; last_u = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_product", 64'(bus_s.product), 64'd0);
    check("rst_ready",   64'(bus_s.ready),   64'd1);
    check("rst_valid",   64'(bus_s.valid),   64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed cases with spec-given constants.
    op_expect(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 32'hFFFE0001);
    op_expect(16'h8000, 16'h8000, 1'b1, 32'h40000000, 32'h40000000);
    op_expect(16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 32'h0004FFF1);
    op_expect(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 32'hFFFE0001);
    op_expect(16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE, 32'h0001FFFE);

    // cs while busy is ignored.
    op(16'd3, 16'd4, 1'b0);
    repeat (4) @(posedge clk);
    #2 cs = 1'b1; a = 16'd7; b = 16'd7;
    @(posedge clk); #2 cs = 1'b0;
    wait_level(1'b1);
    check("ignore_cs", 64'(bus_s.product), 64'd12);

    // Asynchronous reset mid-CALC.
    op(16'h1234, 16'h0010, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_product", 64'(bus_s.product), 64'd0);
    check("midrst_ready",   64'(bus_s.ready),   64'd1);
    check("midrst_valid",   64'(bus_s.valid),   64'd0);
    q.delete();
    last_s = '0; last_u = '0; rdy_edge = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    op_expect(16'd2, 16'd3, 1'b0, 32'd6, 32'd6);

    // Back-to-back with cs held high.
    sgn = 1'b0;
    a = 16'd5; b = 16'd6; cs = 1'b1;
    wait_level(1'b1); wait_level(1'b0);
    a = 16'd0; b = 16'hFFFF;
    wait_level(1'b1); wait_level(1'b0);
    a = 16'hFFFF; b = 16'd1;
    wait_level(1'b1); wait_level(1'b0);
    cs = 1'b0;
    wait_level(1'b1);
    check("b2b_last", 64'(bus_s.product), 64'h0000FFFF);

    // Randomized operations with occasional stray cs while busy.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = pick();
      y = pick();
      op(x, y, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 10)) @(posedge clk);
        #2 cs = 1'b1; a = 16'($urandom); b = 16'($urandom);
        @(posedge clk); #2 cs = 1'b0;
      end
    end

    wait_level(1'b1);
    repeat (3) @(posedge clk);
    #2;
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
